// File: rtl/calc_pkg.sv
// rtl/calc_pkg.sv - shared opcode, display-select, scan-code and FSM state definitions
//
// Purpose: common types for calc_input_sequencer and ps2_key_decode.
// Contents: op_e opcode enum, DS_* display-source encodings,
//           SC_* PS/2 set-2 scan codes, state_e sequencer states.
package calc_pkg;

  typedef enum logic [1:0] {
    OP_NONE = 2'd0,
    OP_ADD  = 2'd1,
    OP_SUB  = 2'd2,
    OP_MUL  = 2'd3
  } op_e;

  localparam logic [2:0] DS_OP1    = 3'd0;
  localparam logic [2:0] DS_OPER   = 3'd1;
  localparam logic [2:0] DS_OP2    = 3'd2;
  localparam logic [2:0] DS_RESULT = 3'd3;
  localparam logic [2:0] DS_ERROR  = 3'd4;

  localparam logic [7:0] SC_BREAK   = 8'hF0;
  localparam logic [7:0] SC_EXT     = 8'hE0;
  localparam logic [7:0] SC_ENTER   = 8'h5A;
  localparam logic [7:0] SC_CLEAR   = 8'h66;
  localparam logic [7:0] SC_ESC     = 8'h76;
  localparam logic [7:0] SC_ADD     = 8'h79;
  localparam logic [7:0] SC_SUB     = 8'h7B;
  localparam logic [7:0] SC_SUB_ALT = 8'h4E;
  localparam logic [7:0] SC_MUL     = 8'h7C;

  typedef enum logic [3:0] {
    ST_ENT1  = 4'd0,
    ST_OPER  = 4'd1,
    ST_ENT2  = 4'd2,
    ST_WR1   = 4'd3,
    ST_WR2   = 4'd4,
    ST_WR3   = 4'd5,
    ST_START = 4'd6,
    ST_WAIT  = 4'd7,
    ST_RD    = 4'd8,
    ST_CAP   = 4'd9,
    ST_SHOW  = 4'd10,
    ST_ERR   = 4'd11
  } state_e;

endpackage

// File: rtl/ps2_key_decode.sv
// rtl/ps2_key_decode.sv - combinational PS/2 set-2 scan code classifier
//
// Purpose: maps one press scan code to its key class.
// Ports:
//   i_code      in  8  scan-code byte
//   o_is_digit  out 1  code is a decimal digit key
//   o_digit     out 4  digit value 0..9 (0 when not a digit)
//   o_is_op     out 1  code is an operator key
//   o_op        out 2  operator (OP_NONE when not an operator)
//   o_is_enter  out 1  enter key
//   o_is_clear  out 1  clear (backspace) key
//   o_is_esc    out 1  escape key
module ps2_key_decode
  import calc_pkg::*;
(
  input  logic [7:0] i_code,
  output logic       o_is_digit,
  output logic [3:0] o_digit,
  output logic       o_is_op,
  output op_e        o_op,
  output logic       o_is_enter,
  output logic       o_is_clear,
  output logic       o_is_esc
);

  always_comb begin
    o_is_digit = 1'b0;
    o_digit    = 4'd0;
    o_is_op    = 1'b0;
    o_op       = OP_NONE;
    o_is_enter = 1'b0;
    o_is_clear = 1'b0;
    o_is_esc   = 1'b0;
    case (i_code)
      8'h45: begin o_is_digit = 1'b1; o_digit = 4'd0; end
      8'h16: begin o_is_digit = 1'b1; o_digit = 4'd1; end
      8'h1E: begin o_is_digit = 1'b1; o_digit = 4'd2; end
      8'h26: begin o_is_digit = 1'b1; o_digit = 4'd3; end
      8'h25: begin o_is_digit = 1'b1; o_digit = 4'd4; end
      8'h2E: begin o_is_digit = 1'b1; o_digit = 4'd5; end
      8'h36: begin o_is_digit = 1'b1; o_digit = 4'd6; end
      8'h3D: begin o_is_digit = 1'b1; o_digit = 4'd7; end
      8'h3E: begin o_is_digit = 1'b1; o_digit = 4'd8; end
      8'h46: begin o_is_digit = 1'b1; o_digit = 4'd9; end
      SC_ADD:             begin o_is_op = 1'b1; o_op = OP_ADD; end
      SC_SUB, SC_SUB_ALT: begin o_is_op = 1'b1; o_op = OP_SUB; end
      SC_MUL:             begin o_is_op = 1'b1; o_op = OP_MUL; end
      SC_ENTER: o_is_enter = 1'b1;
      SC_CLEAR: o_is_clear = 1'b1;
      SC_ESC:   o_is_esc   = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: rtl/calc_input_sequencer.sv
// rtl/calc_input_sequencer.sv - keyboard calculator entry FSM and MIPS mailbox sequencer
//
// Purpose: parses PS/2 press events into op1/operator/op2, writes the three
// mailboxes, starts the core, waits for done (with timeout), captures the
// result and selects what the display shows.
// Ports:
//   i_clk, i_reset             clock, synchronous active-high reset
//   i_key_strobe, i_key_byte   one-cycle strobe and scan-code byte
//   i_mips_done, i_result_in   core done level, result word (valid cycle after rd)
//   o_op1, o_op2, o_opcode     mailbox data
//   o_wr_op1/op2/opcode        mailbox write strobes
//   o_calc_start, o_rd_result  core start pulse, result read strobe
//   o_disp_sel, o_disp_value   display source select and routed value
//   o_busy, o_error            sequence in flight, timeout error
module calc_input_sequencer
  import calc_pkg::*;
#(
  parameter int DATA_W      = 32,
  parameter int MAX_DIGITS  = 4,
  parameter int TIMEOUT_CYC = 1000000,
  parameter int CNT_W       = 20
) (
  input  logic              i_clk,
  input  logic              i_reset,
  input  logic              i_key_strobe,
  input  logic [7:0]        i_key_byte,
  input  logic              i_mips_done,
  input  logic [DATA_W-1:0] i_result_in,
  output logic [DATA_W-1:0] o_op1,
  output logic [DATA_W-1:0] o_op2,
  output logic [DATA_W-1:0] o_opcode,
  output logic              o_wr_op1,
  output logic              o_wr_op2,
  output logic              o_wr_opcode,
  output logic              o_calc_start,
  output logic              o_rd_result,
  output logic [2:0]        o_disp_sel,
  output logic [DATA_W-1:0] o_disp_value,
  output logic              o_busy,
  output logic              o_error
);

  localparam int                DCNT_W   = $clog2(MAX_DIGITS + 1);
  localparam logic [DCNT_W-1:0] DCNT_MAX = DCNT_W'(MAX_DIGITS);
  localparam logic [CNT_W-1:0]  TO_LAST  = CNT_W'(TIMEOUT_CYC - 1);

  function automatic logic [DATA_W-1:0] acc_digit(input logic [DATA_W-1:0] v,
                                                  input logic [3:0]        d);
    return (v * DATA_W'(10)) + DATA_W'(d);
  endfunction

  state_e              r_state;
  logic                r_skip;
  logic [DATA_W-1:0]   r_op1;
  logic [DATA_W-1:0]   r_op2;
  logic [DATA_W-1:0]   r_result;
  op_e                 r_opcode;
  logic [DCNT_W-1:0]   r_cnt1;
  logic [DCNT_W-1:0]   r_cnt2;
  logic [CNT_W-1:0]    r_timer;
  logic                r_wr_op1;
  logic                r_wr_op2;
  logic                r_wr_opcode;
  logic                r_calc_start;
  logic                r_rd_result;
  logic                r_busy;

  logic                w_is_digit;
  logic [3:0]          w_digit;
  logic                w_is_op;
  op_e                 w_op;
  logic                w_is_enter;
  logic                w_is_clear;
  logic                w_is_esc;
  logic                w_press;
  logic                w_key_valid;
  logic                w_in_seq;
  logic [CNT_W-1:0]    w_timer_inc;
  logic [DATA_W-1:0]   w_opcode_ext;
  logic [DATA_W-1:0]   w_digit_ext;
  logic [2:0]          w_disp_sel;
  logic [DATA_W-1:0]   w_disp_value;

  ps2_key_decode u_decode (
    .i_code     (i_key_byte),
    .o_is_digit (w_is_digit),
    .o_digit    (w_digit),
    .o_is_op    (w_is_op),
    .o_op       (w_op),
    .o_is_enter (w_is_enter),
    .o_is_clear (w_is_clear),
    .o_is_esc   (w_is_esc)
  );

  // A press is any strobed byte that is not a prefix and not the byte after F0.
  assign w_press      = i_key_strobe && !r_skip &&
                        (i_key_byte != SC_BREAK) && (i_key_byte != SC_EXT);
  assign w_key_valid  = w_is_digit | w_is_op | w_is_enter | w_is_clear | w_is_esc;
  assign w_in_seq     = (r_state inside {ST_WR1, ST_WR2, ST_WR3, ST_START,
                                         ST_WAIT, ST_RD, ST_CAP});
  assign w_timer_inc  = r_timer + CNT_W'(1);
  assign w_opcode_ext = {{(DATA_W-2){1'b0}}, r_opcode};
  assign w_digit_ext  = {{(DATA_W-4){1'b0}}, w_digit};

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state      <= ST_ENT1;
      r_skip       <= 1'b0;
      r_op1        <= '0;
      r_op2        <= '0;
      r_result     <= '0;
      r_opcode     <= OP_NONE;
      r_cnt1       <= '0;
      r_cnt2       <= '0;
      r_timer      <= '0;
      r_wr_op1     <= 1'b0;
      r_wr_op2     <= 1'b0;
      r_wr_opcode  <= 1'b0;
      r_calc_start <= 1'b0;
      r_rd_result  <= 1'b0;
      r_busy       <= 1'b0;
    end else begin
      r_wr_op1     <= 1'b0;
      r_wr_op2     <= 1'b0;
      r_wr_opcode  <= 1'b0;
      r_calc_start <= 1'b0;
      r_rd_result  <= 1'b0;

      // F0 discards exactly the following byte; E0 is dropped without arming.
      if (i_key_strobe) begin
        if (r_skip)
          r_skip <= 1'b0;
        else if (i_key_byte == SC_BREAK)
          r_skip <= 1'b1;
      end

      if (w_press && (w_is_esc || (r_state == ST_ERR && w_key_valid)) && !w_in_seq) begin
        r_state  <= ST_ENT1;
        r_op1    <= '0;
        r_op2    <= '0;
        r_result <= '0;
        r_opcode <= OP_NONE;
        r_cnt1   <= '0;
        r_cnt2   <= '0;
        r_timer  <= '0;
        r_busy   <= 1'b0;
      end else begin
        case (r_state)
          ST_ENT1: if (w_press) begin
            if (w_is_digit) begin
              if (r_cnt1 < DCNT_MAX) begin
                r_op1  <= acc_digit(r_op1, w_digit);
                r_cnt1 <= r_cnt1 + DCNT_W'(1);
              end
            end else if (w_is_op) begin
              if (r_cnt1 != '0) begin
                r_opcode <= w_op;
                r_state  <= ST_OPER;
              end
            end else if (w_is_clear) begin
              r_op1  <= '0;
              r_cnt1 <= '0;
            end
          end
          ST_OPER: if (w_press) begin
            if (w_is_op) begin
              r_opcode <= w_op;
            end else if (w_is_digit) begin
              r_op2   <= acc_digit(r_op2, w_digit);
              r_cnt2  <= r_cnt2 + DCNT_W'(1);
              r_state <= ST_ENT2;
            end
          end
          ST_ENT2: if (w_press) begin
            if (w_is_digit) begin
              if (r_cnt2 < DCNT_MAX) begin
                r_op2  <= acc_digit(r_op2, w_digit);
                r_cnt2 <= r_cnt2 + DCNT_W'(1);
              end
            end else if (w_is_enter) begin
              if (r_cnt2 != '0) begin
                r_wr_op1 <= 1'b1;
                r_busy   <= 1'b1;
                r_state  <= ST_WR1;
              end
            end else if (w_is_clear) begin
              r_op2  <= '0;
              r_cnt2 <= '0;
            end
          end
          // Strobes are raised on entry so each is high exactly in its state.
          ST_WR1: begin
            r_wr_op2 <= 1'b1;
            r_state  <= ST_WR2;
          end
          ST_WR2: begin
            r_wr_opcode <= 1'b1;
            r_state     <= ST_WR3;
          end
          ST_WR3: begin
            r_calc_start <= 1'b1;
            r_state      <= ST_START;
          end
          ST_START: begin
            r_timer <= '0;
            r_state <= ST_WAIT;
          end
          // The timer reaching TIMEOUT_CYC-1 lands ERR TIMEOUT_CYC cycles
          // after the calc_start cycle.
          ST_WAIT: begin
            if (i_mips_done) begin
              r_rd_result <= 1'b1;
              r_state     <= ST_RD;
            end else if (w_timer_inc == TO_LAST) begin
              r_busy  <= 1'b0;
              r_state <= ST_ERR;
            end else begin
              r_timer <= w_timer_inc;
            end
          end
          ST_RD: r_state <= ST_CAP;
          ST_CAP: begin
            r_result <= i_result_in;
            r_busy   <= 1'b0;
            r_state  <= ST_SHOW;
          end
          ST_SHOW: if (w_press) begin
            if (w_is_digit) begin
              r_op1    <= w_digit_ext;
              r_cnt1   <= DCNT_W'(1);
              r_op2    <= '0;
              r_cnt2   <= '0;
              r_opcode <= OP_NONE;
              r_state  <= ST_ENT1;
            end else if (w_is_op) begin
              r_op1    <= r_result;
              r_cnt1   <= DCNT_W'(1);
              r_op2    <= '0;
              r_cnt2   <= '0;
              r_opcode <= w_op;
              r_state  <= ST_OPER;
            end
          end
          default: ;
        endcase
      end
    end
  end

  always_comb begin
    w_disp_sel   = DS_OP1;
    w_disp_value = r_op1;
    case (r_state)
      ST_ENT1: begin w_disp_sel = DS_OP1;    w_disp_value = r_op1;        end
      ST_OPER: begin w_disp_sel = DS_OPER;   w_disp_value = w_opcode_ext; end
      ST_SHOW: begin w_disp_sel = DS_RESULT; w_disp_value = r_result;     end
      ST_ERR:  begin w_disp_sel = DS_ERROR;  w_disp_value = '0;           end
      // ENT2 and the mailbox/wait states keep operand two on the display.
      default: begin w_disp_sel = DS_OP2;    w_disp_value = r_op2;        end
    endcase
  end

  assign o_op1        = r_op1;
  assign o_op2        = r_op2;
  assign o_opcode     = w_opcode_ext;
  assign o_wr_op1     = r_wr_op1;
  assign o_wr_op2     = r_wr_op2;
  assign o_wr_opcode  = r_wr_opcode;
  assign o_calc_start = r_calc_start;
  assign o_rd_result  = r_rd_result;
  assign o_disp_sel   = w_disp_sel;
  assign o_disp_value = w_disp_value;
  assign o_busy       = r_busy;
  assign o_error      = (r_state == ST_ERR);

endmodule

// File: tb/tb_calc_input_sequencer.sv
// tb/tb_calc_input_sequencer.sv - directed self-checking bench for calc_input_sequencer
module tb_calc_input_sequencer;

  logic        clk = 1'b0;
  logic        reset;
  logic        key_strobe;
  logic [7:0]  key_byte;
  logic        mips_done;
  logic [31:0] result_in;
  logic [31:0] op1, op2, opcode, disp_value;
  logic        wr_op1, wr_op2, wr_opcode, calc_start, rd_result, busy, error;
  logic [2:0]  disp_sel;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  calc_input_sequencer #(
    .DATA_W(32), .MAX_DIGITS(4), .TIMEOUT_CYC(16), .CNT_W(5)
  ) dut (
    .i_clk(clk), .i_reset(reset), .i_key_strobe(key_strobe), .i_key_byte(key_byte),
    .i_mips_done(mips_done), .i_result_in(result_in),
    .o_op1(op1), .o_op2(op2), .o_opcode(opcode),
    .o_wr_op1(wr_op1), .o_wr_op2(wr_op2), .o_wr_opcode(wr_opcode),
    .o_calc_start(calc_start), .o_rd_result(rd_result),
    .o_disp_sel(disp_sel), .o_disp_value(disp_value),
    .o_busy(busy), .o_error(error)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0d expected=%0d", tag, got, exp);
    end
  endtask

  // Presents one byte for one clock; returns at the falling edge after it was taken.
  task automatic send(input logic [7:0] b);
    @(negedge clk);
    key_byte   = b;
    key_strobe = 1'b1;
    @(negedge clk);
    key_strobe = 1'b0;
    key_byte   = 8'h00;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_op1"}, op1, 0);
    check({tag, "_op2"}, op2, 0);
    check({tag, "_opcode"}, opcode, 0);
    check({tag, "_strobes"}, {27'd0, wr_op1, wr_op2, wr_opcode, calc_start, rd_result}, 0);
    check({tag, "_disp_sel"}, {29'd0, disp_sel}, 0);
    check({tag, "_disp_value"}, disp_value, 0);
    check({tag, "_busy_err"}, {30'd0, busy, error}, 0);
  endtask

  initial begin
    logic [7:0] seq1 [12] = '{8'h16, 8'hF0, 8'h16, 8'h1E, 8'hF0, 8'h1E,
                              8'h79, 8'hF0, 8'h79, 8'h26, 8'hF0, 8'h26};
    logic [7:0] dig5 [5]  = '{8'h16, 8'h1E, 8'h26, 8'h25, 8'h2E};

    reset = 1'b1; key_strobe = 1'b0; key_byte = 8'h00; mips_done = 1'b0; result_in = 32'd0;
    repeat (3) @(negedge clk);
    check_all_zero("reset");
    reset = 1'b0;

    // 12 + 3 with break codes interleaved
    foreach (seq1[i]) send(seq1[i]);
    check("t1_op1", op1, 12);
    check("t1_opcode", opcode, 1);
    check("t1_op2", op2, 3);
    check("t1_disp_sel", {29'd0, disp_sel}, 2);
    send(8'h5A);
    check("t1_wr_op1", {29'd0, wr_op1, wr_op2, wr_opcode}, 3'b100);
    check("t1_busy_wr1", {31'd0, busy}, 1);
    @(negedge clk);
    check("t1_wr_op2", {29'd0, wr_op1, wr_op2, wr_opcode}, 3'b010);
    @(negedge clk);
    check("t1_wr_opcode", {28'd0, wr_op1, wr_op2, wr_opcode, calc_start}, 4'b0010);
    @(negedge clk);
    check("t1_calc_start", {28'd0, wr_op1, wr_op2, wr_opcode, calc_start}, 4'b0001);
    check("t1_busy_start", {31'd0, busy}, 1);
    mips_done = 1'b1; result_in = 32'd15;
    @(negedge clk);
    check("t1_no_rd_yet", {31'd0, rd_result}, 0);
    @(negedge clk);
    check("t1_rd_result", {31'd0, rd_result}, 1);
    check("t1_busy_rd", {31'd0, busy}, 1);
    mips_done = 1'b0;
    @(negedge clk);
    check("t1_rd_pulse_end", {31'd0, rd_result}, 0);
    @(negedge clk);
    check("t1_show_sel", {29'd0, disp_sel}, 3);
    check("t1_show_value", disp_value, 15);
    check("t1_show_busy", {31'd0, busy}, 0);

    // Chain from SHOW: 15 + 2, then reset during WAIT
    send(8'h79);
    check("t6_chain_op1", op1, 15);
    check("t6_chain_sel", {29'd0, disp_sel}, 1);
    check("t6_chain_dispval", disp_value, 1);
    send(8'h1E);
    send(8'h5A);
    check("t6_op1", op1, 15);
    check("t6_op2", op2, 2);
    check("t6_opcode", opcode, 1);
    repeat (3) @(negedge clk);
    check("t6_calc_start", {31'd0, calc_start}, 1);
    repeat (3) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check_all_zero("t6_reset_wait");
    reset = 1'b0;
    repeat (4) begin
      @(negedge clk);
      check("t6_no_strobes", {27'd0, wr_op1, wr_op2, wr_opcode, calc_start, rd_result}, 0);
    end

    // Digit limit and clear
    foreach (dig5[i]) send(dig5[i]);
    check("t3_op1_limit", op1, 1234);
    check("t3_dispval", disp_value, 1234);
    send(8'h66);
    check("t3_clear_op1", op1, 0);
    check("t3_clear_sel", {29'd0, disp_sel}, 0);

    // Operator with no digits ignored; operator replacement in OPER
    send(8'h7C);
    check("t4_op_ignored_sel", {29'd0, disp_sel}, 0);
    check("t4_op_ignored_opc", opcode, 0);
    send(8'h3D);
    send(8'h7C);
    check("t4_mul", opcode, 3);
    send(8'h7B);
    check("t4_sub", opcode, 2);
    check("t4_sub_dispval", disp_value, 2);
    send(8'h79);
    send(8'h4E);
    check("t4_sub_alt", opcode, 2);
    // E0 does not arm the skip flag
    send(8'hE0);
    send(8'h3E);
    check("t4_e0_op2", op2, 8);
    check("t4_e0_sel", {29'd0, disp_sel}, 2);

    // Timeout with mips_done held low
    send(8'h5A);
    repeat (3) @(negedge clk);
    check("t5_calc_start", {31'd0, calc_start}, 1);
    for (int k = 1; k <= 16; k++) begin
      @(negedge clk);
      if (k == 15) check("t5_no_err_15", {31'd0, error}, 0);
      if (k == 16) begin
        check("t5_err_16", {31'd0, error}, 1);
        check("t5_err_sel", {29'd0, disp_sel}, 4);
        check("t5_err_busy", {31'd0, busy}, 0);
      end
    end
    send(8'h16);
    check_all_zero("t5_recover");

    // Escape discards the partial entry
    send(8'h46);
    send(8'h79);
    send(8'h76);
    check_all_zero("esc");

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
